// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
interface window_gen_3x3_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic          in_valid;
    logic          in_ready;
    logic          in_pix;
    logic          win_valid;
    logic          win_ready;
    logic [8:0]    X;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          frame_done;

    modport slave (
        input  in_valid, in_pix, win_ready,
        output in_ready, win_valid, X, win_row, win_col, frame_done
    );

    modport master (
        output in_valid, in_pix, win_ready,
        input  in_ready, win_valid, X, win_row, win_col, frame_done
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator over a raster binary image with two line buffers.
// state  | meaning: FILL = rows 0..1 buffering only; STREAM = rows >= 2, emit windows at col >= 2
module window_gen_3x3 #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    window_gen_3x3_if.slave bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {FILL, STREAM} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [IMG_W-1:0] line1;
    logic [IMG_W-1:0] line2;
    logic [8:0]    win_cols;
    logic [8:0]    new_win;
    logic [8:0]    x_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          win_valid_q;
    logic          frame_done_q;
    logic          in_ready_w;
    logic          accept;
    logic          emit;
    logic          col_last;
    logic          row_last;

    assign in_ready_w = !(win_valid_q && !bus.win_ready);
    assign accept     = bus.in_valid && in_ready_w && !clear;
    assign emit       = accept && (state == STREAM) && (col >= CW'(2));
    assign col_last   = (col == COL_LAST);
    assign row_last   = (row == ROW_LAST);

    // Shift columns left; the new right column is {line2, line1, pixel} at col.
    assign new_win = {win_cols[7], win_cols[6], line2[col],
                      win_cols[4], win_cols[3], line1[col],
                      win_cols[1], win_cols[0], bus.in_pix};

    always_ff @(posedge clk) begin
        if (accept) begin
            line2[col] <= line1[col];
            line1[col] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            col          <= '0;
            row          <= '0;
            win_cols     <= '0;
            x_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (clear) begin
            state        <= FILL;
            col          <= '0;
            row          <= '0;
            win_cols     <= '0;
            x_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && col_last && row_last;
            if (accept) begin
                win_cols <= new_win;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                case (state)
                    FILL:   if (col_last && row == RW'(1)) state <= STREAM;
                    STREAM: if (col_last && row_last)      state <= FILL;
                    default: state <= FILL;
                endcase
            end
            if (emit) begin
                x_q         <= new_win;
                row_q       <= row;
                col_q       <= col;
                win_valid_q <= 1'b1;
            end else if (win_valid_q && bus.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.win_valid  = win_valid_q;
    assign bus.X          = x_q;
    assign bus.win_row    = row_q;
    assign bus.win_col    = col_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 image with hand-computed windows.
module tb_window_gen_3x3;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid_r = 1'b0;
    logic in_pix_r = 1'b0;
    logic win_ready_r = 1'b1;

    always #5 clk = ~clk;

    window_gen_3x3_if #(.IMG_W(W), .IMG_H(H)) bus ();

    assign bus.in_valid  = in_valid_r;
    assign bus.in_pix    = in_pix_r;
    assign bus.win_ready = win_ready_r;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [12:0] wq[$];
    int          fd_count = 0;
    bit          bp_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_x = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer: random backpressure only while bp_en is set.
    always @(posedge clk) begin
        #1;
        win_ready_r = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.win_valid && bus.win_ready)
                wq.push_back({bus.win_row, bus.win_col, bus.X});
            if (bus.frame_done) begin
                fd_count++;
                chk("fd_with_last_win", {11'd0, bus.win_valid, bus.win_row, bus.win_col},
                    {11'd0, 1'b1, 2'd3, 2'd3});
            end
            if (bp_en) begin
                chk("bp_in_ready", {15'd0, bus.in_ready}, {15'd0, !(bus.win_valid && !bus.win_ready)});
                if (prev_stall)
                    chk("bp_hold", {6'd0, bus.win_valid, bus.X}, {6'd0, 1'b1, prev_x});
                prev_stall = bus.win_valid && !bus.win_ready;
                prev_x     = bus.X;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    function automatic logic pix_of(input int kind, input int r, input int c);
        case (kind)
            1:       return 1'b1;
            2:       return 1'((r + c) % 2);
            default: return (r == 1 && c == 1);
        endcase
    endfunction

    task automatic send(input logic pix, input int gaps);
        int n;
        repeat (gaps) begin
            @(posedge clk);
            #1;
        end
        in_valid_r = 1'b1;
        in_pix_r   = pix;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) chk("in_ready_timeout", {15'd0, bus.in_ready}, 16'd1);
        @(posedge clk);
        #1;
        in_valid_r = 1'b0;
    endtask

    task automatic send_frame(input int kind, input bit gappy);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(pix_of(kind, r, c), gappy ? $urandom_range(0, 2) : 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bus.win_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", {15'd0, bus.win_valid}, 16'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string scen, input logic [35:0] xs);
        logic [12:0] got;
        logic [12:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = {2'(2 + i / 2), 2'(2 + i % 2), xs[35 - 9 * i -: 9]};
            got = (wq.size() > 0) ? wq.pop_front() : 13'h1FFF;
            chk($sformatf("%s_win%0d", scen, i), {3'd0, got}, {3'd0, exp});
        end
    endtask

    task automatic check_idle(input string tag);
        chk(tag, {1'b0, bus.win_valid, bus.X, bus.win_row, bus.win_col, bus.frame_done}, 16'd0);
    endtask

    localparam logic [35:0] EXP_ONES  = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
    localparam logic [35:0] EXP_CHECK = {9'h0AA, 9'h155, 9'h155, 9'h0AA};
    localparam logic [35:0] EXP_DOT   = {9'h010, 9'h020, 9'h080, 9'h100};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        chk("reset_in_ready", {15'd0, bus.in_ready}, 16'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(1, 1'b0);
        drain();
        chk("s1_count", 16'(wq.size()), 16'd4);
        chk("s1_fd", 16'(fd_count), 16'd1);
        expect4("s1", EXP_ONES);
        fd_count = 0;

        send_frame(2, 1'b0);
        drain();
        chk("s2_count", 16'(wq.size()), 16'd4);
        chk("s2_fd", 16'(fd_count), 16'd1);
        expect4("s2", EXP_CHECK);
        fd_count = 0;

        send_frame(3, 1'b0);
        drain();
        chk("s3_count", 16'(wq.size()), 16'd4);
        chk("s3_fd", 16'(fd_count), 16'd1);
        expect4("s3", EXP_DOT);
        fd_count = 0;

        bp_en = 1'b1;
        send_frame(2, 1'b1);
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        chk("s4_count", 16'(wq.size()), 16'd4);
        chk("s4_fd", 16'(fd_count), 16'd1);
        expect4("s4", EXP_CHECK);
        fd_count = 0;

        // Abort frame A with rst_n after 9 pixels.
        for (int i = 0; i < 9; i++) send(1'b1, 0);
        rst_n = 1'b0;
        #1;
        check_idle("s5_rst_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wq.delete();
        send_frame(3, 1'b0);
        drain();
        chk("s5r_count", 16'(wq.size()), 16'd4);
        chk("s5r_fd", 16'(fd_count), 16'd1);
        expect4("s5r", EXP_DOT);
        fd_count = 0;

        // Same abort through clear, with a pixel offered alongside it.
        for (int i = 0; i < 9; i++) send(1'b1, 0);
        in_valid_r = 1'b1;
        in_pix_r   = 1'b1;
        clear      = 1'b1;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        in_valid_r = 1'b0;
        check_idle("s5_clear_outputs");
        wq.delete();
        send_frame(3, 1'b0);
        drain();
        chk("s5c_count", 16'(wq.size()), 16'd4);
        chk("s5c_fd", 16'(fd_count), 16'd1);
        expect4("s5c", EXP_DOT);
        fd_count = 0;

        send_frame(1, 1'b0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(pix_of(2, r, c), 0);
                if (r == 2 && c == 2)
                    chk("s6_latency", {1'b0, bus.win_valid, bus.X, bus.win_row, bus.win_col, 1'b0},
                        {1'b0, 1'b1, 9'h0AA, 2'd2, 2'd2, 1'b0});
            end
        end
        drain();
        chk("s6_count", 16'(wq.size()), 16'd8);
        chk("s6_fd", 16'(fd_count), 16'd2);
        expect4("s6a", EXP_ONES);
        expect4("s6b", EXP_CHECK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
